win_eval_sched: RTL and testbench
=================================

WIN_EVAL_SCHED -- requirements
Module: win_eval_sched

Interface
REQ-001 The block SHALL have parameter WIN_LEN, default 3, giving the samples per window (legal range 1..15).
REQ-002 The block SHALL have parameter TARGET, default 2, giving the exact ones count that makes a hit (legal range 0..WIN_LEN).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, the asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit, a request to begin windowed evaluation.
REQ-006 The block SHALL have port stop, input, 1 bit, a request to finish after the current window.
REQ-007 The block SHALL have port w, input, 1 bit, the sample stream.
REQ-008 The block SHALL have port res_ready, input, 1 bit, the consumer's acceptance of a result.
REQ-009 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-010 The block SHALL have port res_valid, output, 1 bit, high while a result is offered.
REQ-011 The block SHALL have port res_hit, output, 1 bit, the window verdict, meaningful only while res_valid is high.
REQ-012 The block SHALL have port win_cnt, output, 8 bits, the count of accepted results.

Function
REQ-013 The block SHALL implement an FSM with three states: IDLE, SAMPLE and REPORT.
REQ-014 In IDLE with start=1, the block SHALL enter SAMPLE on the next edge with the sample index and ones count cleared to 0.
REQ-015 In SAMPLE, the block SHALL register w every cycle, add it to the ones count and increment the sample index.
REQ-016 The ones count SHALL be 4 bits wide and SHALL never wrap within a window.
REQ-017 When the sample index equals WIN_LEN-1, the block SHALL enter REPORT on the next edge; res_hit SHALL equal (ones count including that final sample == TARGET).
REQ-018 Window latency SHALL be exactly WIN_LEN cycles in SAMPLE, after which res_valid is asserted on the following cycle.
REQ-019 In REPORT, res_valid SHALL be 1 and res_hit SHALL be held stable until res_ready=1.
REQ-020 In REPORT, w SHALL be ignored; samples arriving there are dropped.
REQ-021 On res_valid && res_ready, win_cnt SHALL increment, wrapping from 255 to 0.
REQ-022 On res_valid && res_ready with no pending stop, the block SHALL enter SAMPLE with the index and count cleared, so back-to-back windows incur one REPORT cycle.
REQ-023 On res_valid && res_ready with a pending stop, the block SHALL enter IDLE and clear the pending stop.
REQ-024 A stop seen in SAMPLE or REPORT SHALL set the pending-stop flag; the current window SHALL always complete and report.
REQ-025 A stop seen in IDLE without start SHALL be ignored.
REQ-026 start and stop together in IDLE SHALL run exactly one window and then return to IDLE.
REQ-027 start SHALL be ignored outside IDLE.
REQ-028 If WIN_LEN=1, each SAMPLE visit SHALL last one cycle.

Reset
REQ-029 While reset=1, the block SHALL asynchronously force IDLE, busy=0, res_valid=0, res_hit=0 and win_cnt=0, and clear the index, ones count and pending stop.
REQ-030 Reset mid-window or mid-REPORT SHALL discard the result without incrementing win_cnt.
REQ-031 After reset deasserts, the block SHALL stay in IDLE until start is seen.

Configuration
REQ-032 With macro WIN_EVAL_HIT_CNT_EN defined, the block SHALL add output hit_cnt (8 bits), which increments on each accepted result with res_hit=1, saturates at 255, and is cleared only by reset.
REQ-033 Without WIN_EVAL_HIT_CNT_EN, port hit_cnt and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 Defaults, start pulse, w=1,0,1, res_ready=1 -> res_valid on cycle 4 after start with res_hit=1 and win_cnt=1.
REQ-035 Defaults, w=1,1,1, res_ready held 0 for 5 cycles -> res_valid and res_hit=0 held stable for all 5 cycles; win_cnt increments only on the accepting cycle.
REQ-036 Continuous run, w=0,1,1 | 1,1,0 | 0,0,0 with res_ready=1 -> results hit, hit, miss; win_cnt=3; one REPORT gap per window; with the macro defined, hit_cnt=2.
REQ-037 stop pulsed on the 2nd SAMPLE cycle -> the window completes, one result is issued, busy=0 on the cycle after acceptance, and win_cnt=1.
REQ-038 Asynchronous reset asserted mid-SAMPLE (between edges) -> busy=0 and res_valid=0 immediately, win_cnt=0, and start is then required to resume.
REQ-039 win_cnt preloaded by running 256 windows -> wraps to 0; with the macro defined, hit_cnt at 255 stays 255 on further hits.

Source files
------------

// File: rtl/win_eval_sched.sv
// -----------------------------------------------------------------------------
// win_eval_sched
//   Collects fixed-length windows of a 1-bit sample stream. Each window is
//   scored as a hit when its ones count equals TARGET. The verdict is offered
//   through a valid/ready handshake. Windows repeat back to back until a stop
//   request is seen, and the current window always finishes first.
//
// Parameters
//   WIN_LEN  samples per window (1..15)
//   TARGET   ones count that makes a hit (0..WIN_LEN)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      begin windowed evaluation (used only in IDLE)
//   stop       finish after the current window
//   w          sample stream
//   res_ready  consumer accepts the offered result
//   busy       high whenever the block is not IDLE
//   res_valid  result offered (REPORT state)
//   res_hit    window verdict, meaningful while res_valid is high
//   win_cnt    accepted results, wraps modulo 256
//   hit_cnt    accepted hits, saturating at 255 (only when the
//              WIN_EVAL_HIT_CNT_EN macro is defined)
// -----------------------------------------------------------------------------
module win_eval_sched #(
    parameter int WIN_LEN = 3,
    parameter int TARGET  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       w,
    input  logic       res_ready,
    output logic       busy,
    output logic       res_valid,
    output logic       res_hit,
`ifdef WIN_EVAL_HIT_CNT_EN
    output logic [7:0] hit_cnt,
`endif
    output logic [7:0] win_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(WIN_LEN - 1);
    localparam logic [3:0] HIT_ONES = 4'(TARGET);

    state_t     state;
    state_t     state_next;
    logic [3:0] idx;
    logic [3:0] ones;
    logic [3:0] ones_next;
    logic       hit_r;
    logic       stop_pend;

    // WIN_LEN <= 15, so four bits hold the largest possible count.
    assign ones_next = ones + {3'b000, w};

    assign busy      = (state != IDLE);
    assign res_valid = (state == REPORT);
    assign res_hit   = hit_r & res_valid;

    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SAMPLE;
            SAMPLE:  if (idx == LAST_IDX) state_next = REPORT;
            REPORT:  if (res_ready) state_next = (stop_pend || stop) ? IDLE : SAMPLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            ones      <= '0;
            hit_r     <= 1'b0;
            stop_pend <= 1'b0;
            win_cnt   <= '0;
`ifdef WIN_EVAL_HIT_CNT_EN
            hit_cnt   <= '0;
`endif
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        ones      <= '0;
                        // start together with stop runs exactly one window.
                        stop_pend <= stop;
                    end
                end
                SAMPLE: begin
                    ones <= ones_next;
                    idx  <= idx + 4'd1;
                    if (stop) stop_pend <= 1'b1;
                    // Verdict includes the final sample taken on this edge.
                    if (idx == LAST_IDX) hit_r <= (ones_next == HIT_ONES);
                end
                REPORT: begin
                    // w is ignored here; the verdict stays frozen until accepted.
                    if (res_ready) begin
                        idx       <= '0;
                        ones      <= '0;
                        stop_pend <= 1'b0;
                        win_cnt   <= win_cnt + 8'd1;
`ifdef WIN_EVAL_HIT_CNT_EN
                        if (hit_r && hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 8'd1;
`endif
                    end else if (stop) begin
                        stop_pend <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_win_eval_sched.sv
// -----------------------------------------------------------------------------
// tb_win_eval_sched
//   Scoreboard bench for win_eval_sched. The driver issues windows on the
//   cycle timeline the block promises. Each finished window pushes its
//   expected verdict and win_cnt into a queue. A monitor pops that queue
//   whenever the DUT offers a result. Define WIN_EVAL_HIT_CNT_EN to also
//   check hit_cnt.
// -----------------------------------------------------------------------------
module tb_win_eval_sched;

    localparam int WIN_LEN = 3;
    localparam int TARGET  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       w;
    logic       res_ready;
    logic       busy;
    logic       res_valid;
    logic       res_hit;
    logic [7:0] win_cnt;
`ifdef WIN_EVAL_HIT_CNT_EN
    logic [7:0] hit_cnt;
`endif

    win_eval_sched #(.WIN_LEN(WIN_LEN), .TARGET(TARGET)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .w         (w),
        .res_ready (res_ready),
        .busy      (busy),
        .res_valid (res_valid),
        .res_hit   (res_hit),
`ifdef WIN_EVAL_HIT_CNT_EN
        .hit_cnt   (hit_cnt),
`endif
        .win_cnt   (win_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       hit;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] m_win_cnt = 8'd0;
    logic [7:0] m_hit_cnt = 8'd0;
    bit         m_pend = 1'b0;
    bit         m_run  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every offered result against the head of the queue.
    always @(negedge clk) begin
        if (reset === 1'b0 && res_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: res_valid=1 with no result expected at %0t", $time);
            end else begin
                check("res_hit", res_hit, exp_q[0].hit);
                check("win_cnt", win_cnt, exp_q[0].cnt);
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Called #1 after an edge with the DUT idle; leaves it in SAMPLE.
    task automatic begin_run(input bit with_stop);
        start  = 1'b1;
        stop   = with_stop;
        m_pend = with_stop;
        m_run  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    // IDLE cycles with stop noise and w toggling: nothing may start.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            stop  = 1'($urandom_range(0, 1));
            w     = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("busy_idle", busy, 0);
        end
        stop = 1'b0;
    endtask

    // Called #1 after the edge that put the DUT into SAMPLE. Drives one window,
    // stalls the consumer for 'stall' cycles, then accepts the result.
    task automatic run_window(input logic [14:0] bits, input int stall,
                              input int stop_at, input bit noise);
        int   ones;
        exp_t e;
        ones = 0;
        for (int i = 0; i < WIN_LEN; i++) begin
            w     = bits[i];
            stop  = (i == stop_at);
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (i == stop_at) m_pend = 1'b1;
            ones += int'(bits[i]);
            @(negedge clk);
            check("busy_sample", busy, 1);
            check("valid_sample", res_valid, 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        stop  = 1'b0;
        e.hit = (ones == TARGET);
        e.cnt = m_win_cnt;
        exp_q.push_back(e);
        for (int i = 0; i <= stall; i++) begin
            res_ready = (i == stall);
            w         = 1'($urandom_range(0, 1));
            stop      = (noise && i < stall) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (stop) m_pend = 1'b1;
            @(negedge clk);
            check("valid_report", res_valid, 1);
            @(posedge clk); #1;
        end
        res_ready = 1'b0;
        stop      = 1'b0;
        m_win_cnt = m_win_cnt + 8'd1;
        if (e.hit && m_hit_cnt != 8'hFF) m_hit_cnt = m_hit_cnt + 8'd1;
        if (m_pend) begin
            m_pend = 1'b0;
            m_run  = 1'b0;
        end
        check("busy_after_accept", busy, m_run);
    endtask

    task automatic apply_reset_model;
        m_win_cnt = 8'd0;
        m_hit_cnt = 8'd0;
        m_pend    = 1'b0;
        m_run     = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; w = 1'b0; res_ready = 1'b0;
        #2;
        check("reset_busy", busy, 0);
        check("reset_valid", res_valid, 0);
        check("reset_hit", res_hit, 0);
        check("reset_win_cnt", win_cnt, 0);
        #20 reset = 1'b0;
        @(posedge clk); #1;
        idle_cycles(3);

        // w=1,0,1 then continuous 0,1,1 | 1,1,0 | 0,0,0: hit, hit, hit, miss.
        begin_run(1'b0);
        run_window(15'b101, 0, -1, 1'b0);
        run_window(15'b110, 0, -1, 1'b0);
        run_window(15'b011, 0, -1, 1'b0);
        run_window(15'b000, 0, 0, 1'b0);
        check("win_cnt_cont", win_cnt, m_win_cnt);
`ifdef WIN_EVAL_HIT_CNT_EN
        check("hit_cnt_cont", hit_cnt, m_hit_cnt);
`endif

        // w=1,1,1 (miss) with the consumer stalled for 5 cycles.
        begin_run(1'b0);
        run_window(15'b111, 5, 2, 1'b0);

        // stop on the second sample: window completes, then IDLE.
        begin_run(1'b0);
        run_window(15'b011, 0, 1, 1'b0);
        idle_cycles(2);

        // start and stop together: exactly one window.
        begin_run(1'b1);
        run_window(15'b001, 1, -1, 1'b0);
        idle_cycles(2);

        // Randomized windows with noise on start/stop/w.
        for (int k = 0; k < 40; k++) begin
            if (!m_run) begin
                idle_cycles($urandom_range(0, 2));
                begin_run($urandom_range(0, 3) == 0);
            end
            run_window(15'($urandom), $urandom_range(0, 3),
                       ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, WIN_LEN - 1)) : -1,
                       1'b1);
        end
        if (m_run) run_window(15'($urandom), 0, 0, 1'b0);
        check("win_cnt_random", win_cnt, m_win_cnt);

        // Reset mid-SAMPLE, between edges.
        begin_run(1'b0);
        w = 1'b1;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("rst_sample_busy", busy, 0);
        check("rst_sample_valid", res_valid, 0);
        check("rst_sample_win_cnt", win_cnt, 0);
        apply_reset_model();
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
        idle_cycles(3);

        // Reset while a result is waiting: discarded, win_cnt stays 0.
        begin_run(1'b0);
        for (int i = 0; i < WIN_LEN; i++) begin
            w = 1'b1;
            @(posedge clk); #1;
        end
        exp_q.push_back('{hit: (WIN_LEN == TARGET), cnt: 8'd0});
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("rst_report_valid", res_valid, 0);
        check("rst_report_win_cnt", win_cnt, 0);
        apply_reset_model();
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
        idle_cycles(2);
        check("rst_report_win_cnt_after", win_cnt, 0);

        // 260 back-to-back hits: win_cnt wraps, hit_cnt saturates.
        begin_run(1'b0);
        for (int k = 0; k < 260; k++) begin
            run_window(15'b011, 0, (k == 259) ? 0 : -1, 1'b0);
            if (k == 255) check("win_cnt_wrap", win_cnt, 0);
        end
        check("win_cnt_final", win_cnt, m_win_cnt);
`ifdef WIN_EVAL_HIT_CNT_EN
        check("hit_cnt_sat", hit_cnt, m_hit_cnt);
`endif
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
